specific_seq_checker: RTL
=========================

SPECIFIC_SEQ_CHECKER -- requirements
Module: specific_seq_checker

Interface
REQ-001 Parameter LOCK_N, default 3: consecutive correct transitions required in CHECK before LOCK is entered; legal range 1..7.
REQ-002 Parameter CNT_W, default 8: width of ERRCNT.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 D  input  3  observed counter code, D[2:0] = Q2 Q1 Q0.
REQ-006 VALID  input  1  D is sampled only on edges where VALID=1.
REQ-007 LOCKED  output  1  high while the FSM is in LOCK.
REQ-008 EXP  output  3  next expected code; value is don't-care in HUNT.
REQ-009 ERR  output  1  one-cycle pulse: a sequence mismatch was detected while in LOCK.
REQ-010 ILLEGAL  output  1  one-cycle pulse: an unused code (1, 4, 6) was sampled in any state.
REQ-011 WRAP  output  1  one-cycle pulse: a correct 7->0 transition was accepted in LOCK.
REQ-012 ERRCNT  output  CNT_W  count of ERR pulses; saturates at all-ones.

Function
REQ-013 The legal sequence shall be 0->2->3->5->7->0; next(0)=2, next(2)=3, next(3)=5, next(5)=7, next(7)=0.
REQ-014 Codes 1, 4 and 6 shall be illegal, and next() shall be undefined for them.
REQ-015 All outputs shall be registered; each response appears on the edge that samples the D value causing it (1-cycle latency).
REQ-016 Cycles with VALID=0 shall hold all state, EXP, LOCKED and ERRCNT, and shall deassert the ERR, ILLEGAL and WRAP pulses.
REQ-017 The FSM shall have three states, HUNT, CHECK and LOCK, plus a match counter MC (0..LOCK_N).
REQ-018 HUNT, legal D: go to CHECK, EXP<=next(D), MC<=0.
REQ-019 HUNT, illegal D: stay in HUNT, pulse ILLEGAL.
REQ-020 CHECK, D==EXP: EXP<=next(D), MC<=MC+1; if MC+1==LOCK_N, go to LOCK and set LOCKED on the same edge.
REQ-021 CHECK, D!=EXP and D legal: reseed (EXP<=next(D), MC<=0), stay in CHECK, no ERR.
REQ-022 CHECK, D illegal: go to HUNT, pulse ILLEGAL, no ERR.
REQ-023 LOCK, D==EXP: stay in LOCK, EXP<=next(D); pulse WRAP if D==0.
REQ-024 LOCK, D!=EXP: pulse ERR, increment ERRCNT (saturating), clear LOCKED.
REQ-025 After REQ-024, a legal D shall send the FSM to CHECK with EXP<=next(D), MC<=0.
REQ-026 After REQ-024, an illegal D shall send the FSM to HUNT and also pulse ILLEGAL; ERR and ILLEGAL are asserted together.
REQ-027 ERRCNT at all-ones shall stay at all-ones; ERR still pulses.
REQ-028 A repeated code (e.g. 1->1, the counter lock-up state) shall be treated as a mismatch.

Reset
REQ-029 CLR=1 at an edge shall force: state HUNT, MC=0, EXP=0, LOCKED=0, ERR=0, ILLEGAL=0, WRAP=0, ERRCNT=0.
REQ-030 CLR shall override VALID and D on the same edge.
REQ-031 CLR asserted mid-LOCK shall lose lock immediately; relock requires the full LOCK_N procedure.

Verification
REQ-032 Lock-up: CLR, then VALID=1 with D=0,2,3,5,7,0 (LOCK_N=3) -> LOCKED rises on the edge sampling 5; WRAP pulses on the final 0; ERR=0 and ERRCNT=0 throughout.
REQ-033 Locked error: when locked with EXP=5, drive D=7 -> ERR=1 for one cycle, ERRCNT=1, LOCKED=0, state CHECK, EXP=0.
REQ-034 Illegal codes: drive D=4 in HUNT, D=6 in CHECK, D=1 in LOCK -> ILLEGAL pulses every time; in LOCK, ERR pulses too and the FSM ends in HUNT.
REQ-035 Stall: when locked, drive VALID=0 for 5 cycles between 3 and 5 -> no pulses, LOCKED stays 1, EXP stays 5.
REQ-036 Saturation: CNT_W=2, force 5 lock/mismatch cycles -> ERRCNT reads 1, 2, 3, 3, 3.
REQ-037 Reset priority: when locked, drive CLR=1 with VALID=1 and D=EXP -> all outputs 0, state HUNT; the next sequence takes LOCK_N+1 valid samples to relock.

Source files
------------

// File: rtl/specific_seq_checker.sv
// Checks a 3-bit counter against the fixed code sequence 0->2->3->5->7->0.
// Hunts for a legal code, confirms LOCK_N consecutive matches, then flags any deviation.
module specific_seq_checker #(
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [2:0]       d,
  input  logic             valid,
  output logic             locked,
  output logic [2:0]       exp,
  output logic             err,
  output logic             illegal,
  output logic             wrap,
  output logic [CNT_W-1:0] errcnt
);

  typedef enum logic [1:0] {StHunt, StCheck, StLock} state_e;

  localparam logic [2:0]       LockN  = 3'(LOCK_N);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       mc_q, mc_d;
  logic [2:0]       exp_q, exp_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             illegal_q, illegal_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd2) || (c == 3'd3) || (c == 3'd5) || (c == 3'd7);
  endfunction

  // Illegal codes have no successor; they never reach this function on a used path.
  function automatic logic [2:0] next_code(input logic [2:0] c);
    logic [2:0] n;
    n = 3'd0;
    case (c)
      3'd0:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd5;
      3'd5:    n = 3'd7;
      3'd7:    n = 3'd0;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    exp_d     = exp_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    illegal_d = 1'b0;
    wrap_d    = 1'b0;
    errcnt_d  = errcnt_q;

    if (valid) begin
      case (state_q)
        StHunt: begin
          if (is_legal(d)) begin
            state_d = StCheck;
            exp_d   = next_code(d);
            mc_d    = 3'd0;
          end else begin
            illegal_d = 1'b1;
          end
        end

        StCheck: begin
          if (!is_legal(d)) begin
            state_d   = StHunt;
            illegal_d = 1'b1;
            mc_d      = 3'd0;
          end else if (d == exp_q) begin
            exp_d = next_code(d);
            mc_d  = mc_q + 3'd1;
            if ((mc_q + 3'd1) == LockN) begin
              state_d  = StLock;
              locked_d = 1'b1;
            end
          end else begin
            // Legal but out of order: restart the match count from this code.
            exp_d = next_code(d);
            mc_d  = 3'd0;
          end
        end

        StLock: begin
          if (d == exp_q) begin
            exp_d  = next_code(d);
            wrap_d = (d == 3'd0);
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            mc_d     = 3'd0;
            if (errcnt_q != CntMax) begin
              errcnt_d = errcnt_q + CNT_W'(1);
            end
            if (is_legal(d)) begin
              state_d = StCheck;
              exp_d   = next_code(d);
            end else begin
              state_d   = StHunt;
              illegal_d = 1'b1;
            end
          end
        end

        default: begin
          state_d  = StHunt;
          locked_d = 1'b0;
          mc_d     = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= StHunt;
      mc_q      <= 3'd0;
      exp_q     <= 3'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      illegal_q <= 1'b0;
      wrap_q    <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      mc_q      <= mc_d;
      exp_q     <= exp_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      illegal_q <= illegal_d;
      wrap_q    <= wrap_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign locked  = locked_q;
  assign exp     = exp_q;
  assign err     = err_q;
  assign illegal = illegal_q;
  assign wrap    = wrap_q;
  assign errcnt  = errcnt_q;

  assert property (@(posedge clk) err |-> !locked);
  assert property (@(posedge clk) wrap |-> locked);

endmodule
